// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register and its helpers.
package pipe_pkg;

  localparam int unsigned INSTR_W_DEFAULT = 32;
  localparam int unsigned PC_W_DEFAULT    = 32;
  localparam int unsigned CNT_W_DEFAULT   = 16;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module pipe_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flushable pipeline stage register with a two-entry skid buffer and registered in_ready.
// Optional stall/flush statistics counters are enabled by defining PIPE_STAT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          INSTR_W   = INSTR_W_DEFAULT,
  parameter int unsigned          PC_W      = PC_W_DEFAULT,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int unsigned          CNT_W     = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pcplus4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pcplus4,
  output pipe_state_e        dbg_state
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  // Handshake: a word moves upstream->stage when in_valid && in_ready, and
  // stage->downstream when out_valid && out_ready, both sampled at posedge clk.
  // Once in_valid or out_valid is raised the payload must stay stable until the transfer.

  pipe_state_e        state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               accept;
  logic               drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          main_instr_d = in_instr;
          main_pc_d    = in_pcplus4;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pcplus4;
        end else if (accept) begin
          state_d      = ST_TWO;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pcplus4;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d      = ST_ONE;
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over every transition; data regs may be written but are ignored once invalid.
    if (flush) begin
      state_d = ST_EMPTY;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    main_instr_q <= main_instr_d;
    main_pc_q    <= main_pc_d;
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_valid_q ? main_instr_q : NOP_INSTR;
  assign out_pcplus4 = out_valid_q ? main_pc_q : '0;
  assign dbg_state   = state_q;

`ifdef PIPE_STAT_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid_q && !out_ready),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scenario tasks with a FIFO scoreboard.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned IW = 32;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 4;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] in_instr = '0;
  logic [PW-1:0] in_pcplus4 = '0;
  logic          in_ready;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [PW-1:0] out_pcplus4;
  pipe_state_e   dbg_state;
`ifdef PIPE_STAT_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [IW+PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .INSTR_W   (IW),
    .PC_W      (PW),
    .NOP_INSTR (NOP),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pcplus4  (in_pcplus4),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pcplus4 (out_pcplus4),
    .dbg_state   (dbg_state)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic drive(input logic v, input logic [IW-1:0] ins, input logic [PW-1:0] pc,
                       input logic ordy, input logic fl);
    in_valid   = v;
    in_instr   = ins;
    in_pcplus4 = pc;
    out_ready  = ordy;
    flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0004, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || out_pcplus4 !== '0 ||
          in_ready !== 1'b1 || dbg_state !== ST_EMPTY) begin
        failures++;
        $display("FAIL reset_state: valid=%b instr=%h pc=%h ready=%b state=%0d, required 0/%h/0/1/0",
                 out_valid, out_instr, out_pcplus4, in_ready, dbg_state, NOP);
      end
    end
    rst = 1'b0;
    drive(1'b1, 32'h0000_1111, 32'h0000_0100, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0000_1111 || out_pcplus4 !== 32'h0000_0100 ||
        dbg_state !== ST_ONE) begin
      failures++;
      $display("FAIL reset_first_word: valid=%b instr=%h pc=%h state=%0d, required 1/00001111/00000100/1",
               out_valid, out_instr, out_pcplus4, dbg_state);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 32'hA000_0000 + i, 32'h0000_1000 + 4 * i, 1'b1, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_in_ready: cycle %0d in_ready=%b, required 1", i, in_ready);
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stream_no_bubble: cycle %0d out_valid=%b, required 1", i, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_sb: got %h, required nothing", {out_instr, out_pcplus4});
        end else begin
          if ({out_instr, out_pcplus4} !== exp_q[0]) begin
            failures++;
            $display("FAIL stream_sb: got %h, required %h", {out_instr, out_pcplus4}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_instr, in_pcplus4});
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: pending=%0d out_valid=%b, required 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_back_pressure();
    int idx = 0;
    for (int c = 0; c < 10; c++) begin
      drive(idx < 3, 32'hB000_0000 + idx, 32'h0000_2000 + 4 * idx, c >= 4, 1'b0);
      if (c == 1) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_c1: in_ready=%b, required 1", in_ready);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (in_ready !== 1'b0 || dbg_state !== ST_TWO || out_instr !== 32'hB000_0000) begin
          failures++;
          $display("FAIL bp_hold: cycle %0d in_ready=%b state=%0d instr=%h, required 0/2/b0000000",
                   c, in_ready, dbg_state, out_instr);
        end
      end
      if (c == 4) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_lag: in_ready=%b, required 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_sb: got %h, required nothing", {out_instr, out_pcplus4});
        end else begin
          if ({out_instr, out_pcplus4} !== exp_q[0]) begin
            failures++;
            $display("FAIL bp_sb: got %h, required %h", {out_instr, out_pcplus4}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_instr, in_pcplus4});
        idx++;
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || idx != 3 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_end: pending=%0d sent=%0d out_valid=%b, required 0/3/0",
               exp_q.size(), idx, out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hC000_0000, 32'h0000_3000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC000_0001, 32'h0000_3004, 1'b0, 1'b0);
    tick();
    checks++;
    if (dbg_state !== ST_TWO || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_setup: state=%0d in_ready=%b, required 2/0", dbg_state, in_ready);
    end
    drive(1'b1, 32'hC000_0002, 32'h0000_3008, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pcplus4 !== '0 ||
        in_ready !== 1'b1 || dbg_state !== ST_EMPTY) begin
      failures++;
      $display("FAIL flush_two: valid=%b instr=%h pc=%h ready=%b state=%0d, required 0/%h/0/1/0",
               out_valid, out_instr, out_pcplus4, in_ready, dbg_state, NOP);
    end
    drive(1'b1, 32'hE000_0000, 32'h0000_4000, 1'b0, 1'b0);
    tick();
    // Flush in ONE with concurrent accept and drain: E0 completes, C3 is dropped.
    drive(1'b1, 32'hC000_0003, 32'h0000_300C, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hE000_0000 || out_pcplus4 !== 32'h0000_4000) begin
      failures++;
      $display("FAIL flush_accept_after: valid=%b instr=%h pc=%h, required 1/e0000000/00004000",
               out_valid, out_instr, out_pcplus4);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL flush_one_drop: cycle %0d valid=%b instr=%h ready=%b, required 0/%h/1",
                 c, out_valid, out_instr, in_ready, NOP);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 32'hD000_0000, 32'h0000_5000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hD000_0001, 32'h0000_5004, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hD000_0000 || dbg_state !== ST_ONE) begin
      failures++;
      $display("FAIL simul_d0: valid=%b instr=%h state=%0d, required 1/d0000000/1",
               out_valid, out_instr, dbg_state);
    end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hD000_0001 || out_pcplus4 !== 32'h0000_5004 ||
        dbg_state !== ST_ONE || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_d1: valid=%b instr=%h pc=%h state=%0d ready=%b, required 1/d0000001/00005004/1/1",
               out_valid, out_instr, out_pcplus4, dbg_state, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_end: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0);
      end else begin
        drive(1'b0, '0, '0, 1'b1, 1'b0);
      end
      if (!out_valid) begin
        checks++;
        if (out_instr !== NOP || out_pcplus4 !== '0) begin
          failures++;
          $display("FAIL rand_bubble: cycle %0d instr=%h pc=%h, required %h/0",
                   c, out_instr, out_pcplus4, NOP);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_sb: cycle %0d got %h, required nothing", c, {out_instr, out_pcplus4});
        end else begin
          if ({out_instr, out_pcplus4} !== exp_q[0]) begin
            failures++;
            $display("FAIL rand_sb: cycle %0d got %h, required %h", c, {out_instr, out_pcplus4}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_instr, in_pcplus4});
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_end: pending=%0d out_valid=%b, required 0/0", exp_q.size(), out_valid);
    end
  endtask

`ifdef PIPE_STAT_EN
  task automatic test_stats();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      failures++;
      $display("FAIL stat_reset: stall=%0d flush=%0d, required 0/0", stall_cnt, flush_cnt);
    end
    drive(1'b1, 32'hF000_0000, 32'h0000_6000, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) begin
        checks++;
        if (stall_cnt !== 4'd10) begin
          failures++;
          $display("FAIL stat_stall_mid: stall=%0d, required 10", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL stat_stall_sat: stall=%0d, required 15", stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (flush_cnt !== 4'd3) begin
      failures++;
      $display("FAIL stat_flush: flush=%0d, required 3", flush_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      failures++;
      $display("FAIL stat_clear: stall=%0d flush=%0d, required 0/0", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_simultaneous();
    test_random();
`ifdef PIPE_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
